// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit:
//   - funct3 operation codes (mdu_ctl_e)
//   - sequencer state encodings (mdu_state_e)
//   - default width and iteration count
//   - helpers that classify an operation as divide and give operand signedness
package mul_div_unit_pkg;

  localparam int MDU_XLEN = 32;
  localparam int MDU_ITER = MDU_XLEN;

  typedef enum logic [2:0] {
    MDU_CTL_MUL    = 3'b000,
    MDU_CTL_MULH   = 3'b001,
    MDU_CTL_MULHSU = 3'b010,
    MDU_CTL_MULHU  = 3'b011,
    MDU_CTL_DIV    = 3'b100,
    MDU_CTL_DIVU   = 3'b101,
    MDU_CTL_REM    = 3'b110,
    MDU_CTL_REMU   = 3'b111
  } mdu_ctl_e;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'b00,
    MDU_ST_CALC = 2'b01,
    MDU_ST_FIX  = 2'b10,
    MDU_ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic ctl_is_div(input mdu_ctl_e ctl);
    return ctl[2];
  endfunction

  // Op1 is treated as signed by every op except the fully unsigned ones.
  function automatic logic ctl_op1_signed(input mdu_ctl_e ctl);
    logic s;
    case (ctl)
      MDU_CTL_MULHU, MDU_CTL_DIVU, MDU_CTL_REMU: s = 1'b0;
      default:                                   s = 1'b1;
    endcase
    return s;
  endfunction

  // Op2 is signed only for the fully signed ops.
  function automatic logic ctl_op2_signed(input mdu_ctl_e ctl);
    logic s;
    case (ctl)
      MDU_CTL_MUL, MDU_CTL_MULH, MDU_CTL_DIV, MDU_CTL_REM: s = 1'b1;
      default:                                             s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Radix-2 shift-add
//   multiply and restoring divide on operand magnitudes, with sign fix-up in
//   a final cycle. Fixed latency: Done_o pulses 34 cycles after the accept edge.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Start_i; Res_o holds the last result
//   CALC  | one multiply/divide bit per cycle, ITER cycles
//   FIX   | sign correction; result registered at the end of this cycle
//   DONE  | Done_o pulse, Res_o valid
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   Start_i      request strobe, sampled only in IDLE
//   Kill_i       abort (pipeline flush), priority over Start_i
//   MulDivCtl_i  funct3 operation select
//   Op1_i        rs1 (multiplicand / dividend)
//   Op2_i        rs2 (multiplier / divisor)
//   Busy_o       high in CALC and FIX
//   Done_o       one-cycle result-valid pulse
//   Res_o        result, held until the next completed op
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int ITER = XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Start_i,
  input  logic            Kill_i,
  input  logic [2:0]      MulDivCtl_i,
  input  logic [XLEN-1:0] Op1_i,
  input  logic [XLEN-1:0] Op2_i,
  output logic            Busy_o,
  output logic            Done_o,
  output logic [XLEN-1:0] Res_o
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  mdu_ctl_e         ctl_q;
  logic [XLEN-1:0]  mcand_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  acc_hi_q;  // product high half / partial remainder
  logic [XLEN-1:0]  acc_lo_q;  // multiplier bits -> product low half / dividend -> quotient
  logic [XLEN-1:0]  res_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div_zero_q;

  logic accept;
  logic last_iter;

  assign accept    = (state_q == MDU_ST_IDLE) && Start_i && !Kill_i;
  assign last_iter = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (Kill_i) begin
      state_d = MDU_ST_IDLE;
    end else begin
      case (state_q)
        MDU_ST_IDLE: if (Start_i) state_d = MDU_ST_CALC;
        MDU_ST_CALC: if (last_iter) state_d = MDU_ST_FIX;
        MDU_ST_FIX:  state_d = MDU_ST_DONE;
        MDU_ST_DONE: state_d = MDU_ST_IDLE;
        default:     state_d = MDU_ST_IDLE;
      endcase
    end
  end

  // Operand preparation at accept: the datapath only ever sees magnitudes.
  mdu_ctl_e        ctl_in;
  logic            op1_neg, op2_neg;
  logic [XLEN-1:0] op1_mag, op2_mag;

  always_comb begin
    ctl_in  = mdu_ctl_e'(MulDivCtl_i);
    op1_neg = ctl_op1_signed(ctl_in) & Op1_i[XLEN-1];
    op2_neg = ctl_op2_signed(ctl_in) & Op2_i[XLEN-1];
    op1_mag = op1_neg ? -Op1_i : Op1_i;
    op2_mag = op2_neg ? -Op2_i : Op2_i;
  end

  // One iteration step for each kind of op.
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    // Partial remainder stays below the divisor, so bit XLEN of the
    // difference is a reliable borrow flag.
    div_diff  = div_shift - {1'b0, mcand_q};
  end

  // Sign fix-up and result selection, consumed in FIX.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    // Divide-by-zero keeps the all-ones quotient regardless of signs.
    quo_fix  = (neg_res_q && !div_zero_q) ? -acc_lo_q : acc_lo_q;
    rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
    case (ctl_q)
      MDU_CTL_MUL:                                 res_d = prod_fix[XLEN-1:0];
      MDU_CTL_MULH, MDU_CTL_MULHSU, MDU_CTL_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
      MDU_CTL_DIV, MDU_CTL_DIVU:                   res_d = quo_fix;
      default:                                     res_d = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      ctl_q      <= MDU_CTL_MUL;
      mcand_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      res_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (Kill_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q      <= CNT_LOAD;
      ctl_q      <= ctl_in;
      acc_hi_q   <= '0;
      neg_res_q  <= op1_neg ^ op2_neg;
      neg_rem_q  <= op1_neg;
      div_zero_q <= (Op2_i == '0);
      if (ctl_is_div(ctl_in)) begin
        mcand_q  <= op2_mag;
        acc_lo_q <= op1_mag;
      end else begin
        mcand_q  <= op1_mag;
        acc_lo_q <= op2_mag;
      end
    end else if (state_q == MDU_ST_CALC) begin
      if (!last_iter) cnt_q <= cnt_q - CNT_W'(1);
      if (ctl_is_div(ctl_q)) begin
        if (!div_diff[XLEN]) begin
          acc_hi_q <= div_diff[XLEN-1:0];
          acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_hi_q <= div_shift[XLEN-1:0];
          acc_lo_q <= {acc_lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi_q <= mul_sum[XLEN:1];
        acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
    end else if (state_q == MDU_ST_FIX) begin
      res_q <= res_d;
    end
  end

  assign Busy_o = (state_q == MDU_ST_CALC) || (state_q == MDU_ST_FIX);
  assign Done_o = (state_q == MDU_ST_DONE);
  assign Res_o  = res_q;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle RV32M multiply/divide responder in the EX stage, alongside the single-cycle ALU.
- Pipeline control is the initiator: it issues a request with Start_i, holds the pipeline on Busy_o, and captures Res_o on Done_o.
- Iterative radix-2 datapath: shift-add for multiply, restoring division for divide. Fixed latency for every op.

Parameters:
- XLEN, 32, operand/result width.
- ITER, XLEN, number of CALC iterations (one bit per cycle).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- Start_i  input  1  request strobe; sampled only in IDLE
- Kill_i  input  1  abort in-flight op (pipeline flush)
- MulDivCtl_i  input  3  funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111
- Op1_i  input  XLEN  rs1 (multiplicand / dividend)
- Op2_i  input  XLEN  rs2 (multiplier / divisor)
- Busy_o  output  1  high in CALC/FIX; drives the stall
- Done_o  output  1  one-cycle pulse; Res_o valid
- Res_o  output  XLEN  result, held until the next accepted Start_i

Behaviour:
- States: IDLE -> CALC (ITER cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
- Reset (any state, including mid-op): state IDLE; Busy_o=0, Done_o=0, Res_o=0, iteration counter=0.
- Accept: Start_i=1 in IDLE at edge N latches ctl, operand magnitudes, signs and the divisor-zero flag.
  - Busy_o=1 for cycles N+1..N+33.
  - Done_o=1 in cycle N+34.
  - Inputs are ignored after the accept edge.
- Start_i in CALC/FIX/DONE is ignored. Back-to-back issue: Start_i may be high in the cycle after DONE, i.e. earliest re-accept is in IDLE.
- Kill_i=1 in any state: IDLE next cycle, no Done_o, Res_o unchanged. Kill_i has priority over Start_i.
- Signedness:
  - MUL/MULH: both operands signed.
  - MULHSU: Op1 signed, Op2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
  - The datapath always operates on unsigned magnitudes.
- Multiply: 64-bit product accumulated over ITER cycles. FIX negates the full 64 bits if the signs differ. MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide: restoring, one quotient bit per cycle, producing quotient and remainder magnitudes. In FIX:
  - quotient is negated if signs differ;
  - remainder is negated if the dividend is negative.
- Divide by zero (Op2=0): quotient=0xFFFFFFFF (quotient sign fix suppressed), remainder=Op1. Latency is still 34.
- Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0. This falls out of the magnitude path; no special case is needed.
- Res_o updates only in the DONE cycle.
- Done_o is never high while Busy_o is high.

Decomposition:
- Const.v gains:
  - `MDU_CTL_MUL .. `MDU_CTL_REMU (3-bit funct3 codes);
  - `MDU_ST_IDLE/CALC/FIX/DONE (2-bit state encodings);
  - `MDU_ITER (32).
- No sub-module. The 64-bit conditional negator and restoring-step subtractor stay inline; the datapath is a single shift register pair plus a counter.

Test Plan:
- MUL 7 * 6 -> Res_o=0x0000002A; Done_o high exactly 34 cycles after the Start_i edge; Busy_o high for 33 cycles.
- MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- DIVU 5 / 0 -> 0xFFFFFFFF; REM 0xFFFFFFF9 % 0 -> 0xFFFFFFF9; DIV 0xFFFFFFF9 / 0 -> 0xFFFFFFFF.
- Start_i re-asserted with new operands at cycle N+10 -> ignored; first result delivered unchanged at N+34. Kill_i at N+20 -> no Done_o, Busy_o low at N+21, Res_o keeps its prior value, next Start_i accepted.
- rst_i asserted at N+15 -> next cycle Busy_o=0, Done_o=0, Res_o=0; no Done_o pulse follows; a fresh op completes normally.
